midi_voice_alloc: RTL and testbench
===================================

Name: midi_voice_alloc

Overview:
- Voice-allocation scheduler between the MIDI byte receiver and the note display/tone outputs.
- Consumes received MIDI bytes and parses channel voice messages with running status.
- Shares a fixed pool of NUM_VOICES voice slots among incoming notes: free slot first, else steals the oldest.
- Publishes the per-voice note/velocity table and a one-cycle allocation event.

Parameters:
- NUM_VOICES, 4, number of voice slots (2..8)
- CHANNEL, 0, MIDI channel accepted (0..15); other channels ignored
- AGE_W, 4, width of per-voice saturating age counter

Ports:
- clck  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- byte_valid  in  1  one-cycle strobe, byte_data holds a received byte
- byte_data  in  8  received MIDI byte
- frame_err  in  1  qualifies byte_valid; byte had bad stop bit
- voice_on  out  NUM_VOICES  bit v set when voice v holds a note
- voice_note  out  7*NUM_VOICES  note number of voice v at [7v+6:7v]
- voice_vel  out  7*NUM_VOICES  velocity of voice v, same packing
- alloc_pulse  out  1  one-cycle strobe, a voice was (re)assigned
- alloc_idx  out  3  index of voice assigned on alloc_pulse
- steal_pulse  out  1  one-cycle strobe, allocation evicted an active voice

Behaviour:
- Reset (async, any time incl. mid-message): all outputs 0, all ages 0, running status cleared, parser IDLE.
- Parser states: IDLE (no running status), WAIT_D1, WAIT_D2.
- Status 0x8C/0x9C/0xBC (C = CHANNEL): latch kind (OFF/ON/CC) as running status, go WAIT_D1.
- Any other status 0x80-0xEF: running status = IGNORE, go WAIT_D1; data bytes are counted but produce no action.
- Status 0xF0-0xF7: clear running status, go IDLE.
- Status 0xF8-0xFF (realtime): no effect on any state, including mid-message.
- Data byte in IDLE: dropped.
- WAIT_D1 data: latch d1, go WAIT_D2.
- WAIT_D2 data: execute message, return to WAIT_D1 (running status kept).
- Status byte in WAIT_D2: aborts the partial message, then processed as above.
- byte_valid with frame_err=1: byte discarded, running status cleared, IDLE.
- Execute happens in the cycle byte_valid carries d2; voice outputs and pulses are registered and visible the following cycle (latency 1). One byte per cycle is accepted, with no backpressure.
- NOTE_ON with vel>0, note n, resolved in this priority:
  1. An active voice already holds n: retrigger it (update vel, age 0, alloc_pulse, no steal).
  2. Otherwise use the lowest-index free voice.
  3. Otherwise steal the voice with maximum age (ties: lowest index); steal_pulse=1.
- On any allocation, every other active voice's age increments, saturating at 2^AGE_W-1.
- NOTE_ON with vel=0 is treated as NOTE_OFF.
- NOTE_OFF n: clear voice_on for the voice holding n (at most one exists). Note and vel fields are retained. Age of a free voice is don't-care, reset to 0. No match: no action, no pulse.
- CC with d1=123 or 120: clear all voice_on in one cycle. Other CC numbers: ignored.
- alloc_pulse and steal_pulse are 0 in every cycle with no allocation.
- Data bytes are 7-bit; bit 7 of a data byte is 0 by definition.

Decomposition:
- Package midi_pkg: status-nibble constants (8, 9, B), CC_ALL_NOTES_OFF=123, CC_ALL_SOUND_OFF=120, parser state enum, running-status kind enum.
- Sub-module midi_voice_select: combinational. Takes voice_on, notes, ages and the request note. Returns hit/hit_idx, free/free_idx and oldest_idx.

Test Plan:
- 0x90 0x3C 0x64 -> next cycle voice_on=0001, voice_note[0]=0x3C, vel[0]=0x64, alloc_pulse=1, alloc_idx=0.
- Running status: 0x90 3C 40 3E 40 40 40 -> voices 0,1,2 hold 0x3C, 0x3E, 0x40, three alloc_pulses, no status byte between.
- Steal: fill 4 voices with notes 60-63, then 0x90 0x40 0x7F -> voice 0 (age 3, oldest) gets 0x40, steal_pulse=1, alloc_idx=0.
- 0x90 0x3C 0x00 and 0x80 0x3C 0x10 both free the voice holding 0x3C; 0x80 on a non-held note causes no output change.
- Realtime 0xF8 inserted between d1 and d2 -> message still executes. frame_err on d1 -> message dropped, following data bytes ignored until a new status.
- 0x91 (wrong channel) 3C 40 -> no change; 0xB0 0x7B 0x00 with 3 voices active -> voice_on=0000 next cycle. rst asserted mid-message clears everything immediately.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared constants and enums for the MIDI voice allocator: status nibbles,
// the two "all off" controller numbers and the parser/running-status encodings.
package midi_pkg;

  localparam logic [3:0] NIB_NOTE_OFF = 4'h8;
  localparam logic [3:0] NIB_NOTE_ON  = 4'h9;
  localparam logic [3:0] NIB_CC       = 4'hB;

  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;
  localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;

  typedef enum logic [1:0] {
    P_IDLE,
    P_WAIT_D1,
    P_WAIT_D2
  } parse_state_t;

  typedef enum logic [2:0] {
    RS_NONE,
    RS_OFF,
    RS_ON,
    RS_CC,
    RS_IGNORE
  } run_status_t;

endpackage

// File: rtl/midi_voice_select.sv
// Combinational voice lookup: active voice holding the requested note, lowest
// free voice, and the oldest voice (largest age, lowest index on ties).
module midi_voice_select #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 4
) (
  input  logic [NUM_VOICES-1:0]            voice_on,
  input  logic [NUM_VOICES-1:0][6:0]       notes,
  input  logic [NUM_VOICES-1:0][AGE_W-1:0] ages,
  input  logic [6:0]                       req_note,
  output logic                             hit,
  output logic [2:0]                       hit_idx,
  output logic                             free,
  output logic [2:0]                       free_idx,
  output logic [2:0]                       oldest_idx
);

  logic [AGE_W-1:0] best_age;

  // Ascending scan with first-found flags gives lowest-index priority everywhere.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = 3'd0;
    free       = 1'b0;
    free_idx   = 3'd0;
    oldest_idx = 3'd0;
    best_age   = ages[0];
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (voice_on[i] && notes[i] == req_note && !hit) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
      if (!voice_on[i] && !free) begin
        free     = 1'b1;
        free_idx = 3'(i);
      end
      if (ages[i] > best_age) begin
        best_age   = ages[i];
        oldest_idx = 3'(i);
      end
    end
  end

endmodule

// File: rtl/midi_voice_alloc.sv
// MIDI channel-voice parser with running status feeding a fixed pool of voice
// slots; notes take a retriggered, free or oldest (stolen) voice.
module midi_voice_alloc
  import midi_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int CHANNEL    = 0,
  parameter int AGE_W      = 4
) (
  input  logic                    clck,
  input  logic                    rst,
  input  logic                    byte_valid,
  input  logic [7:0]              byte_data,
  input  logic                    frame_err,
  output logic [NUM_VOICES-1:0]   voice_on,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_vel,
  output logic                    alloc_pulse,
  output logic [2:0]              alloc_idx,
  output logic                    steal_pulse
);

  parse_state_t state, state_next;
  run_status_t  rs, rs_next;
  logic [6:0]   d1, d1_next;
  logic         exec;

  logic [NUM_VOICES-1:0]            on_q;
  logic [NUM_VOICES-1:0][6:0]       note_q;
  logic [NUM_VOICES-1:0][6:0]       vel_q;
  logic [NUM_VOICES-1:0][AGE_W-1:0] age_q;

  logic       hit, free;
  logic [2:0] hit_idx, free_idx, oldest_idx, sel_idx;
  logic       do_on, do_off, do_clear, steal;
  logic [6:0] d2;

  assign d2 = byte_data[6:0];

  always_ff @(posedge clck or posedge rst) begin
    if (rst) begin
      state <= P_IDLE;
      rs    <= RS_NONE;
      d1    <= 7'd0;
    end else begin
      state <= state_next;
      rs    <= rs_next;
      d1    <= d1_next;
    end
  end

  // Realtime bytes (F8-FF) fall through every branch and leave the parser untouched.
  always_comb begin
    state_next = state;
    rs_next    = rs;
    d1_next    = d1;
    exec       = 1'b0;
    if (byte_valid) begin
      if (frame_err) begin
        state_next = P_IDLE;
        rs_next    = RS_NONE;
      end else if (byte_data[7]) begin
        if (byte_data[7:4] == 4'hF) begin
          if (!byte_data[3]) begin
            state_next = P_IDLE;
            rs_next    = RS_NONE;
          end
        end else begin
          state_next = P_WAIT_D1;
          rs_next    = RS_IGNORE;
          if (byte_data[3:0] == 4'(CHANNEL)) begin
            case (byte_data[7:4])
              NIB_NOTE_OFF: rs_next = RS_OFF;
              NIB_NOTE_ON:  rs_next = RS_ON;
              NIB_CC:       rs_next = RS_CC;
              default:      rs_next = RS_IGNORE;
            endcase
          end
        end
      end else begin
        case (state)
          P_WAIT_D1: begin
            d1_next    = d2;
            state_next = P_WAIT_D2;
          end
          P_WAIT_D2: begin
            exec       = 1'b1;
            state_next = P_WAIT_D1;
          end
          default: state_next = P_IDLE;
        endcase
      end
    end
  end

  midi_voice_select #(
    .NUM_VOICES(NUM_VOICES),
    .AGE_W     (AGE_W)
  ) u_select (
    .voice_on  (on_q),
    .notes     (note_q),
    .ages      (age_q),
    .req_note  (d1),
    .hit       (hit),
    .hit_idx   (hit_idx),
    .free      (free),
    .free_idx  (free_idx),
    .oldest_idx(oldest_idx)
  );

  assign do_on    = exec && rs == RS_ON && d2 != 7'd0;
  assign do_off   = exec && (rs == RS_OFF || (rs == RS_ON && d2 == 7'd0));
  assign do_clear = exec && rs == RS_CC &&
                    (d1 == CC_ALL_NOTES_OFF || d1 == CC_ALL_SOUND_OFF);
  assign steal    = !hit && !free;
  assign sel_idx  = hit ? hit_idx : (free ? free_idx : oldest_idx);

  // Free voices keep their note/velocity but restart their age at zero.
  always_ff @(posedge clck or posedge rst) begin
    if (rst) begin
      on_q        <= '0;
      note_q      <= '0;
      vel_q       <= '0;
      age_q       <= '0;
      alloc_pulse <= 1'b0;
      alloc_idx   <= 3'd0;
      steal_pulse <= 1'b0;
    end else begin
      alloc_pulse <= 1'b0;
      steal_pulse <= 1'b0;
      if (do_on) begin
        alloc_pulse <= 1'b1;
        alloc_idx   <= sel_idx;
        steal_pulse <= steal;
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (sel_idx == 3'(v)) begin
            on_q[v]   <= 1'b1;
            note_q[v] <= d1;
            vel_q[v]  <= d2;
            age_q[v]  <= '0;
          end else if (on_q[v] && age_q[v] != '1) begin
            age_q[v] <= age_q[v] + AGE_W'(1);
          end
        end
      end else if (do_off && hit) begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (hit_idx == 3'(v)) begin
            on_q[v]  <= 1'b0;
            age_q[v] <= '0;
          end
        end
      end else if (do_clear) begin
        on_q  <= '0;
        age_q <= '0;
      end
    end
  end

  assign voice_on   = on_q;
  assign voice_note = note_q;
  assign voice_vel  = vel_q;

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Scoreboard bench for midi_voice_alloc: directed MIDI byte streams push the
// expected voice events; a forked monitor pops and compares on each DUT event.
module tb_midi_voice_alloc;

  localparam int NV = 4;

  logic          clck = 1'b0;
  logic          rst = 1'b1;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          frame_err = 1'b0;
  logic [NV-1:0] voice_on;
  logic [7*NV-1:0] voice_note;
  logic [7*NV-1:0] voice_vel;
  logic          alloc_pulse;
  logic [2:0]    alloc_idx;
  logic          steal_pulse;

  always #5 clck = ~clck;

  midi_voice_alloc #(
    .NUM_VOICES(NV),
    .CHANNEL   (0),
    .AGE_W     (4)
  ) dut (
    .clck       (clck),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err),
    .voice_on   (voice_on),
    .voice_note (voice_note),
    .voice_vel  (voice_vel),
    .alloc_pulse(alloc_pulse),
    .alloc_idx  (alloc_idx),
    .steal_pulse(steal_pulse)
  );

  typedef struct {
    bit          alloc;
    bit [2:0]    idx;
    bit          steal;
    bit [6:0]    note;
    bit [6:0]    vel;
    bit [NV-1:0] on;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_fail = 0;
  logic [NV-1:0] prev_on = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic ferr = 1'b0);
    @(posedge clck);
    #1;
    byte_valid = 1'b1;
    byte_data  = b;
    frame_err  = ferr;
  endtask

  task automatic idleCycles(input int n);
    @(posedge clck);
    #1;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    repeat (n) @(posedge clck);
  endtask

  task automatic expectAlloc(input bit [2:0] idx, input bit stl, input bit [6:0] note,
                             input bit [6:0] vel, input bit [NV-1:0] on);
    exp_t e;
    e.alloc = 1'b1; e.idx = idx; e.steal = stl; e.note = note; e.vel = vel; e.on = on;
    sb.push_back(e);
  endtask

  task automatic expectOn(input bit [NV-1:0] on);
    exp_t e;
    e.alloc = 1'b0; e.idx = 3'd0; e.steal = 1'b0; e.note = 7'd0; e.vel = 7'd0; e.on = on;
    sb.push_back(e);
  endtask

  task automatic checkResetState();
    checkOutput("rst_voice_on", 32'(voice_on), 32'd0);
    checkOutput("rst_voice_note", 32'(voice_note), 32'd0);
    checkOutput("rst_voice_vel", 32'(voice_vel), 32'd0);
    checkOutput("rst_alloc_pulse", 32'(alloc_pulse), 32'd0);
    checkOutput("rst_alloc_idx", 32'(alloc_idx), 32'd0);
    checkOutput("rst_steal_pulse", 32'(steal_pulse), 32'd0);
  endtask

  // A DUT event is any pulse or any change of the voice_on mask.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clck);
      if (rst) begin
        prev_on = voice_on;
      end else begin
        if (alloc_pulse || steal_pulse || voice_on != prev_on) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_event", {alloc_pulse, steal_pulse, 26'd0, voice_on}, 32'd0);
          end else begin
            e = sb.pop_front();
            checkOutput("alloc_pulse", 32'(alloc_pulse), 32'(e.alloc));
            checkOutput("steal_pulse", 32'(steal_pulse), 32'(e.steal));
            checkOutput("voice_on", 32'(voice_on), 32'(e.on));
            if (e.alloc) begin
              checkOutput("alloc_idx", 32'(alloc_idx), 32'(e.idx));
              checkOutput("voice_note", 32'(voice_note[7*e.idx +: 7]), 32'(e.note));
              checkOutput("voice_vel", 32'(voice_vel[7*e.idx +: 7]), 32'(e.vel));
            end
          end
        end
        prev_on = voice_on;
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    #12;
    checkResetState();
    @(posedge clck);
    #1 rst = 1'b0;

    // Fill all four voices using running status after the first note.
    applyStimulus(8'h90); applyStimulus(8'h3C);
    expectAlloc(3'd0, 1'b0, 7'h3C, 7'h64, 4'b0001); applyStimulus(8'h64);
    applyStimulus(8'h3E); expectAlloc(3'd1, 1'b0, 7'h3E, 7'h40, 4'b0011); applyStimulus(8'h40);
    applyStimulus(8'h40); expectAlloc(3'd2, 1'b0, 7'h40, 7'h40, 4'b0111); applyStimulus(8'h40);
    applyStimulus(8'h41); expectAlloc(3'd3, 1'b0, 7'h41, 7'h40, 4'b1111); applyStimulus(8'h40);

    // Steal oldest, retrigger a held note, then steal the new oldest.
    applyStimulus(8'h50); expectAlloc(3'd0, 1'b1, 7'h50, 7'h7F, 4'b1111); applyStimulus(8'h7F);
    applyStimulus(8'h3E); expectAlloc(3'd1, 1'b0, 7'h3E, 7'h22, 4'b1111); applyStimulus(8'h22);
    applyStimulus(8'h51); expectAlloc(3'd2, 1'b1, 7'h51, 7'h33, 4'b1111); applyStimulus(8'h33);

    // Note-off forms: velocity zero, explicit 0x80, and a note nobody holds.
    applyStimulus(8'h41); expectOn(4'b0111); applyStimulus(8'h00);
    applyStimulus(8'h80); applyStimulus(8'h3E); expectOn(4'b0101); applyStimulus(8'h10);
    applyStimulus(8'h3C); applyStimulus(8'h10);
    idleCycles(2);

    // Realtime byte between data bytes; frame error drops the message.
    applyStimulus(8'h90); applyStimulus(8'h45); applyStimulus(8'hF8);
    expectAlloc(3'd1, 1'b0, 7'h45, 7'h30, 4'b0111); applyStimulus(8'h30);
    applyStimulus(8'h90); applyStimulus(8'h46, 1'b1); applyStimulus(8'h46); applyStimulus(8'h20);
    idleCycles(2);
    applyStimulus(8'h90); applyStimulus(8'h46);
    expectAlloc(3'd3, 1'b0, 7'h46, 7'h20, 4'b1111); applyStimulus(8'h20);

    // Other channel is ignored, including its running-status data.
    applyStimulus(8'h91); applyStimulus(8'h3C); applyStimulus(8'h40);
    applyStimulus(8'h3D); applyStimulus(8'h41);

    // Controllers: plain CC ignored, all-notes-off clears the pool.
    applyStimulus(8'h80); applyStimulus(8'h46); expectOn(4'b0111); applyStimulus(8'h00);
    applyStimulus(8'hB0); applyStimulus(8'h07); applyStimulus(8'h64);
    applyStimulus(8'hB0); applyStimulus(8'h7B); expectOn(4'b0000); applyStimulus(8'h00);

    // System status cancels running status; new status aborts a partial message.
    applyStimulus(8'h90); applyStimulus(8'hF0); applyStimulus(8'h3C); applyStimulus(8'h40);
    applyStimulus(8'h90); applyStimulus(8'h3C); applyStimulus(8'h90); applyStimulus(8'h47);
    expectAlloc(3'd0, 1'b0, 7'h47, 7'h11, 4'b0001); applyStimulus(8'h11);
    applyStimulus(8'hB0); applyStimulus(8'h78); expectOn(4'b0000); applyStimulus(8'h00);
    applyStimulus(8'h90); applyStimulus(8'h48);
    expectAlloc(3'd0, 1'b0, 7'h48, 7'h05, 4'b0001); applyStimulus(8'h05);

    // Reset in the middle of a message: outputs clear at once, parser restarts idle.
    applyStimulus(8'h49);
    @(posedge clck);
    #1 byte_valid = 1'b0;
    #2 rst = 1'b1;
    #1 checkResetState();
    @(posedge clck);
    #1 rst = 1'b0;
    applyStimulus(8'h22); applyStimulus(8'h33);
    idleCycles(5);

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
